// File: rtl/klp_pkg.sv
// Shared types and constants for the hazard scheduler.
//   hs_state_t  : scheduler FSM state (RUN/STALL/FLUSH)
//   hs_entry_t  : one in-flight writer record {valid, rd}
//   REG_ZERO    : architectural zero register address
//   STALL_CNT_W : width of the saturating stall counter
//   TRK_DEPTH   : number of tracked downstream stages (EX, MEM, WB)
package klp_pkg;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         STALL_CNT_W = 16;
  localparam int         TRK_DEPTH   = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hs_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } hs_entry_t;

endpackage

// File: rtl/hs_tracker.sv
// In-flight destination tracker: a 3-deep shift register of writer records
// (index 0 = EX, 1 = MEM, 2 = WB) plus the RAW match against the ID sources.
// Ports:
//   clk, reset          : clock, async active-high reset (clears all entries)
//   issue, issue_rd     : ID instruction entering EX this cycle and its rd
//   rs1/rs1_used, rs2/rs2_used : ID source addresses and read qualifiers
//   hit                 : some used, non-zero source matches a valid entry
module hs_tracker
  import klp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       issue,
  input  logic [4:0] issue_rd,
  input  logic [4:0] rs1,
  input  logic       rs1_used,
  input  logic [4:0] rs2,
  input  logic       rs2_used,
  output logic       hit
);

  hs_entry_t            ent [TRK_DEPTH];
  logic [TRK_DEPTH-1:0] hit1, hit2;

  // x0 writers never become valid, so they can never match anything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TRK_DEPTH; i++) ent[i] <= '0;
    end else begin
      ent[0] <= '{valid: issue && (issue_rd != REG_ZERO), rd: issue_rd};
      for (int i = 1; i < TRK_DEPTH; i++) ent[i] <= ent[i-1];
    end
  end

  // WB participates: the register file writes on the same edge ID reads,
  // so ID would otherwise see the stale value.
  for (genvar g = 0; g < TRK_DEPTH; g++) begin : g_match
    assign hit1[g] = ent[g].valid && (ent[g].rd == rs1);
    assign hit2[g] = ent[g].valid && (ent[g].rd == rs2);
  end

  assign hit = (rs1_used && (rs1 != REG_ZERO) && (|hit1)) ||
               (rs2_used && (rs2 != REG_ZERO) && (|hit2));

endmodule

// File: rtl/hazard_sched.sv
// RAW hazard / redirect scheduler for a 5-stage in-order pipeline.
// Stall and flush controls are combinational from the current ID contents,
// the tracker and the EX redirect, so a hazard stalls in the cycle it appears.
// Ports:
//   clk, reset        : clock, async active-high reset
//   i_id_*            : ID instruction sources, destination and qualifiers
//   i_ex_redirect     : EX resolved a taken branch/jump
//   o_stall_if/_id    : hold PC+IF/ID, hold ID
//   o_flush_id/_ex    : squash IF/ID, load bubble into ID/EX
//   o_state           : FSM state (debug)
//   o_stall_count     : saturating count of cycles with o_stall_id=1
module hazard_sched
  import klp_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_id_valid,
  input  logic [4:0]             i_id_rs1,
  input  logic [4:0]             i_id_rs2,
  input  logic                   i_id_rs1_used,
  input  logic                   i_id_rs2_used,
  input  logic [4:0]             i_id_rd,
  input  logic                   i_id_reg_wr_en,
  input  logic                   i_ex_redirect,
  output logic                   o_stall_if,
  output logic                   o_stall_id,
  output logic                   o_flush_id,
  output logic                   o_flush_ex,
  output logic [1:0]             o_state,
  output logic [STALL_CNT_W-1:0] o_stall_count
);

  hs_state_t              state;
  logic                   trk_hit, hazard, issue;
  logic [STALL_CNT_W-1:0] stall_cnt;

  hs_tracker u_trk (
    .clk      (clk),
    .reset    (reset),
    .issue    (issue),
    .issue_rd (i_id_rd),
    .rs1      (i_id_rs1),
    .rs1_used (i_id_rs1_used),
    .rs2      (i_id_rs2),
    .rs2_used (i_id_rs2_used),
    .hit      (trk_hit)
  );

  assign hazard = i_id_valid && trk_hit;

  // Outputs are gated by reset so they read 0 while reset is held,
  // regardless of what the ID/EX inputs present.
  always_comb begin
    o_stall_if = 1'b0;
    o_stall_id = 1'b0;
    o_flush_id = 1'b0;
    o_flush_ex = 1'b0;
    if (!reset) begin
      if (i_ex_redirect) begin
        // Redirect wins: a stalled ID instruction is wrong-path, drop it.
        o_flush_id = 1'b1;
        o_flush_ex = 1'b1;
      end else if (hazard) begin
        o_stall_if = 1'b1;
        o_stall_id = 1'b1;
        o_flush_ex = 1'b1;
      end
      // Second wrong-path fetch arrives one cycle after the redirect.
      if (state == FLUSH) o_flush_id = 1'b1;
    end
  end

  // Only writers of a real register that actually leave ID enter the tracker.
  assign issue = i_id_valid && i_id_reg_wr_en && !o_stall_id && !o_flush_ex;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN:     if (i_ex_redirect) state <= FLUSH;
                 else if (hazard)   state <= STALL;
        STALL:   if (i_ex_redirect) state <= FLUSH;
                 else if (!hazard)  state <= RUN;
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            stall_cnt <= '0;
    else if (o_stall_id && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

  assign o_state       = state;
  assign o_stall_count = stall_cnt;

endmodule

// File: doc/hazard_sched.md
HAZARD_SCHED -- requirements
Module: hazard_sched

Interface
REQ-001 The block SHALL expose these ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- i_id_valid  in  1  ID stage holds a real instruction
- i_id_rs1  in  5  ID source register 1 address
- i_id_rs2  in  5  ID source register 2 address
- i_id_rs1_used  in  1  rs1 is actually read
- i_id_rs2_used  in  1  rs2 is actually read
- i_id_rd  in  5  ID destination register
- i_id_reg_wr_en  in  1  ID instruction writes rd
- i_ex_redirect  in  1  EX instruction resolved a taken branch/jump
- o_stall_if  out  1  hold PC and IF/ID register
- o_stall_id  out  1  hold ID inputs; inject bubble into EX
- o_flush_id  out  1  squash IF/ID contents (become NOP)
- o_flush_ex  out  1  ID/EX register loads a bubble
- o_state  out  2  FSM state, for debug
- o_stall_count  out  16  saturating count of stall cycles

Function
REQ-002 The tracker SHALL hold three entries (EX, MEM, WB), each {valid, rd}; only rd != 0 with wr_en is recorded as valid.
REQ-003 Every cycle: WB <= MEM, MEM <= EX, EX <= issued ID entry; the ID entry is issued only when i_id_valid=1, o_stall_id=0 and o_flush_ex=0, otherwise EX <= invalid.
REQ-004 A hazard SHALL exist, combinationally, when (rs1_used & rs1 != 0 & rs1 matches any valid entry's rd) or the same condition holds for rs2, qualified by i_id_valid. The WB entry counts, because the register file writes at the clock edge and ID reads the old value.
REQ-005 FSM states SHALL be RUN=0, STALL=1 and FLUSH=2.
- RUN: hazard -> STALL; i_ex_redirect -> FLUSH.
- STALL: no hazard -> RUN; i_ex_redirect -> FLUSH.
- FLUSH: always returns to RUN after exactly 1 cycle.
REQ-006 The FSM SHALL drive outputs combinationally from the current inputs.
- Hazard and no redirect: o_stall_if=1, o_stall_id=1, o_flush_ex=1, o_flush_id=0.
- Redirect: o_flush_id=1, o_flush_ex=1, o_stall_if=0, o_stall_id=0.
- Redirect takes priority over hazard in the same cycle.
REQ-007 In FLUSH, o_flush_id=1 for that cycle. This squashes the second wrong-path instruction fetched while the redirect propagated.
REQ-008 Stall latency SHALL be 0 cycles: the stall asserts in the same cycle the hazard appears. Worst-case RAW stall is 3 cycles, with the producer in EX.
REQ-009 o_stall_count SHALL increment by 1 on each cycle with o_stall_id=1 and saturate at 16'hFFFF; it does not wrap.
REQ-010 An instruction writing x0 SHALL never create a tracker entry, and reading x0 SHALL never stall.
REQ-011 When rs1 == rs2 and both match, the block SHALL behave the same as a single match.
REQ-012 A redirect during STALL SHALL discard the stalled ID instruction, since it is flushed and its entry is never issued.

Reset
REQ-013 While reset=1, every output and all tracker entries SHALL be 0 or invalid, state SHALL be RUN, and o_stall_count SHALL be 0, independent of clk.
REQ-014 On reset assertion mid-stall or mid-flush, the block SHALL leave the state at once and drop all in-flight entries.
REQ-015 After reset deasserts, the first instruction SHALL issue with no spurious stall.

Structure
REQ-016 The package klp_pkg SHALL hold:
- the state enum hs_state_t (RUN/STALL/FLUSH);
- the tracker entry struct hs_entry_t {valid, rd[4:0]};
- constant REG_ZERO=5'd0;
- constant STALL_CNT_W=16.
REQ-017 One sub-module, hs_tracker, SHALL hold the 3-entry shift register and the match logic; the FSM and counter sit in hazard_sched.

Verification
REQ-018 Bench scenarios:
- Back-to-back dependency: cycle N issues rd=x5, cycle N+1 ID reads rs1=x5 -> stall exactly 3 cycles, o_stall_count=3, issue on 4th cycle.
- Gap of two: rd=x5 issued, two independent instrs, then rs2=x5 -> 1 stall cycle (WB match).
- x0 case: rd=x0 writer then rs1=x0 reader -> zero stalls, tracker stays empty.
- Redirect while stalled: hazard active, i_ex_redirect=1 for 1 cycle -> o_flush_id=1 that cycle and the next (FLUSH), o_stall_id=0, state RUN after 2 cycles, stalled instr never issued.
- Saturation: force 70000 consecutive hazard cycles -> o_stall_count holds at 16'hFFFF.
- Async reset: assert reset mid-STALL between clock edges -> outputs 0 and state RUN immediately; first post-reset instr issues without stall.
